tone_generator_multi: RTL and testbench



---
 rtl/tone_generator_multi.sv | 148 ++++++++++++++
 tb/tb_tone_generator_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator_multi.sv
// Multi-voice tone generator (saw/pulse/triangle/noise): tick -> voice k at edge T+1+k, no backpressure.
// Ring modulation of triangle voices is built only with TONE_GENERATOR_MULTI_RING_MOD_EN defined.
module tone_generator_multi #(
   parameter int ACCUMULATOR_BITS = 24,
   parameter int OUTPUT_BITS      = 12,
   parameter int NUM_VOICES       = 4,
   parameter int FREQ_BITS        = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sample_tick,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
   input  logic [1:0]                    cfg_addr,
   input  logic [FREQ_BITS-1:0]          cfg_wdata,
   output logic                          busy,
   output logic                          dout_valid,
   output logic [$clog2(NUM_VOICES)-1:0] dout_voice,
   output logic [OUTPUT_BITS-1:0]        dout
);
   localparam int A  = ACCUMULATOR_BITS;
   localparam int O  = OUTPUT_BITS;
   localparam int N  = NUM_VOICES;
   localparam int VW = $clog2(NUM_VOICES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state, state_nxt;
   logic [VW-1:0]  idx, idx_nxt;

   logic [A-1:0]         acc  [N];
   logic [FREQ_BITS-1:0] freq [N];
   logic [O-1:0]         pw   [N];
   logic [4:0]           ctrl [N];
   logic [22:0]          lfsr [N];

   logic [A-1:0]  acc_cur, acc_nxt;
   logic [4:0]    ctl;
   logic          test, shift, fold;
   logic [22:0]   lfsr_cur, lfsr_nxt;
   logic [O-1:0]  top, tri_t, sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: if (sample_tick) begin
            state_nxt = RUN;
            idx_nxt   = '0;
         end
         RUN: begin
            if (idx == VW'(N - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + VW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);

`ifdef TONE_GENERATOR_MULTI_RING_MOD_EN
   logic [VW-1:0] mod_idx;
   logic          mod_msb;

   // Modulator is the previous voice; voice 0 sees the last voice from the prior pass.
   always_comb begin
      mod_idx = (idx == '0) ? VW'(N - 1) : idx - VW'(1);
      mod_msb = acc[mod_idx][A-1];
   end
`endif

   // Test mode pins the oscillator at its reset phase, so the sample is derived from zero.
   always_comb begin
      acc_cur  = acc[idx];
      ctl      = ctrl[idx];
      test     = ctl[3];
      acc_nxt  = test ? '0 : acc_cur + A'(freq[idx]);
      shift    = !test && !acc_cur[A-5] && acc_nxt[A-5];
      lfsr_cur = lfsr[idx];
      if (test)
         lfsr_nxt = '1;
      else if (shift)
         lfsr_nxt = {lfsr_cur[21:0], lfsr_cur[22] ^ lfsr_cur[17]};
      else
         lfsr_nxt = lfsr_cur;
      top   = acc_nxt[A-1 -: O];
      tri_t = acc_nxt[A-2 -: O];
      fold  = acc_nxt[A-1];
`ifdef TONE_GENERATOR_MULTI_RING_MOD_EN
      if (ctl[4])
         fold = fold ^ mod_msb;
`endif
      case (ctl[1:0])
         2'd0:    sample = top;
         2'd1:    sample = (top < pw[idx]) ? '1 : '0;
         2'd2:    sample = fold ? ~tri_t : tri_t;
         default: sample = lfsr_nxt[22 -: O];
      endcase
      if (!ctl[2])
         sample = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < N; v++) begin
            acc[v]  <= '0;
            freq[v] <= '0;
            pw[v]   <= {1'b1, {(O-1){1'b0}}};
            ctrl[v] <= '0;
            lfsr[v] <= '1;
         end
         dout_valid <= 1'b0;
         dout_voice <= '0;
         dout       <= '0;
      end else begin
         if (state == RUN) begin
            acc[idx]   <= acc_nxt;
            lfsr[idx]  <= lfsr_nxt;
            dout_voice <= idx;
            dout       <= sample;
         end
         dout_valid <= (state == RUN);
         // Step above reads the pre-write value; a same-cycle write lands for the next pass.
         if (cfg_we) begin
            case (cfg_addr)
               2'd0:    freq[cfg_voice] <= cfg_wdata;
               2'd1:    pw[cfg_voice]   <= cfg_wdata[O-1:0];
               2'd2:    ctrl[cfg_voice] <= cfg_wdata[4:0];
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tone_generator_multi.sv
// Directed bench for tone_generator_multi at default parameters (A=24, O=12, N=4, F=16).
module tb_tone_generator_multi;
   logic        clk, rst_n, sample_tick, cfg_we;
   logic [1:0]  cfg_voice, cfg_addr;
   logic [15:0] cfg_wdata;
   logic        busy, dout_valid;
   logic [1:0]  dout_voice;
   logic [11:0] dout;

   tone_generator_multi dut (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
      .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .busy(busy), .dout_valid(dout_valid), .dout_voice(dout_voice), .dout(dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_pass = 0;
   int          n_chk  = 0;
   logic [11:0] sam [4];
   logic [1:0]  vox [4];
   int          vld_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic cfg(input int v, input int a, input int d);
      cfg_we    = 1'b1;
      cfg_voice = v[1:0];
      cfg_addr  = a[1:0];
      cfg_wdata = d[15:0];
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic run_tick();
      vld_cnt     = 0;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (dout_valid) vld_cnt++;
         sam[k] = dout;
         vox[k] = dout_voice;
      end
      @(negedge clk);
      if (dout_valid) vld_cnt++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [23:0] a0, a1, an;
   logic [22:0] lf;
   logic [11:0] t, ex;
   logic        fold, ring_on;
   int          cnt;

   initial begin
`ifdef TONE_GENERATOR_MULTI_RING_MOD_EN
      ring_on = 1'b1;
`else
      ring_on = 1'b0;
`endif
      rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
      cfg_voice = '0; cfg_addr = '0; cfg_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_voice", dout_voice, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // saw, gate only on voice 0
      cfg(0, 0, 'h1000);
      cfg(0, 2, 'h4);
      run_tick();
      chk("saw_t1", sam[0], 'h001);
      chk("saw_vld_cnt", vld_cnt, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("saw_voice%0d", k), vox[k], k);
      for (int k = 1; k < 4; k++) chk($sformatf("ungated%0d", k), sam[k], 0);
      repeat (15) run_tick();
      chk("saw_t16", sam[0], 'h010);

      // pulse
      do_reset();
      cfg(0, 2, 'h5);
      cfg(0, 1, 'h800);
      cfg(0, 0, 'h8000);
      for (int n = 1; n <= 512; n++) begin
         run_tick();
         if (n == 1)   chk("pulse_t1", sam[0], 'hFFF);
         if (n == 255) chk("pulse_t255", sam[0], 'hFFF);
         if (n == 256) chk("pulse_t256", sam[0], 'h000);
         if (n == 512) chk("pulse_t512", sam[0], 'hFFF);
      end
      cfg(0, 1, 0);
      run_tick();
      chk("pulse_pw0", sam[0], 'h000);

      // triangle and test bit
      do_reset();
      cfg(1, 2, 'h6);
      cfg(1, 0, 'h1000);
      for (int n = 1; n <= 3072; n++) begin
         run_tick();
         if (n == 1024) chk("tri_t1024", sam[1], 'h800);
         if (n == 2048) chk("tri_t2048", sam[1], 'hFFF);
         if (n == 3072) chk("tri_t3072", sam[1], 'h7FF);
      end
      cfg(1, 2, 'hE);
      run_tick();
      chk("test_a", sam[1], 'h000);
      run_tick();
      chk("test_b", sam[1], 'h000);
      cfg(1, 2, 'h6);
      run_tick();
      chk("test_release", sam[1], 'h002);

      // noise against a reference LFSR
      do_reset();
      cfg(2, 2, 'h7);
      cfg(2, 0, 'h40000);
      repeat (3) run_tick();
      chk("noise_frozen", sam[2], 'hFFF);
      cfg(2, 0, 'h8000);
      a0 = '0;
      lf = '1;
      for (int n = 1; n <= 900; n++) begin
         if (n == 101) cfg(2, 0, 'hFFFF);
         an = a0 + ((n <= 100) ? 24'h8000 : 24'hFFFF);
         if (!a0[19] && an[19]) lf = {lf[21:0], lf[22] ^ lf[17]};
         a0 = an;
         run_tick();
         chk($sformatf("noise_t%0d", n), sam[2], lf[22:11]);
      end

      // tick while busy is ignored, including on the last RUN cycle
      do_reset();
      cfg(0, 0, 'h1000);
      cfg(0, 2, 'h4);
      cnt = 0;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dout_valid) cnt++;
         if (i == 0 || i == 2) sample_tick = 1'b1;
         else sample_tick = 1'b0;
      end
      chk("busy_tick_ignored", cnt, 4);

      // asynchronous reset mid-pass
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("midpass_valid_before", dout_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("midpass_busy", busy, 0);
      chk("midpass_valid", dout_valid, 0);
      chk("midpass_dout", dout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dout_valid) cnt++;
      end
      chk("midpass_aborted", cnt, 0);
      cfg(0, 2, 'h4);
      run_tick();
      chk("freq_reset", sam[0], 'h000);

      // ring modulation (or its absence)
      do_reset();
      cfg(0, 0, 'h8000);
      cfg(1, 0, 'h1000);
      cfg(1, 2, 'h16);
      a0 = '0;
      a1 = '0;
      for (int n = 1; n <= 300; n++) begin
         a0   = a0 + 24'h8000;
         a1   = a1 + 24'h1000;
         fold = a1[23] ^ (ring_on & a0[23]);
         t    = a1[22:11];
         ex   = fold ? ~t : t;
         run_tick();
         if (n % 4 == 0 || n > 250) chk($sformatf("ring_t%0d", n), sam[1], ex);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
